uart_tx: RTL and testbench

Serial UART transmitter that turns parallel bytes into an asynchronous line frame: start bit, 8 data bits LSB first, optional even parity, one stop bit. It is the sending end of the link whose receiving end is `uart_rx`, and uses the same oversampling ratio (8 clocks per bit), so a `uart_tx` → `uart_rx` loopback on one clock must round-trip every byte. A 4-entry input FIFO lets the host queue bytes, and frames are sent back-to-back with no idle gap.

---
 rtl/uart_tx_if.sv | 28 ++
 rtl/uart_tx.sv | 173 +++++++++++++++++
 tb/tb_uart_tx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Host-side byte stream into the UART transmitter plus its serial line and status.
// No latency of its own; pure grouping of the transmitter's host signals.
// Backpressure: the host may only push while ready is high; other pushes are dropped.
interface uart_tx_if;
  logic [7:0] data_out;
  logic       send;
  logic       ready;
  logic       tx;
  logic       busy;

  // Host side: drives bytes, watches flow control, line and status
  modport master (
    output data_out,
    output send,
    input  ready,
    input  tx,
    input  busy
  );

  // Transmitter side
  modport slave (
    input  data_out,
    input  send,
    output ready,
    output tx,
    output busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: queued bytes go out as start, 8 data bits LSB first, [even parity], stop.
// Latency: a byte pushed into an idle, empty transmitter drives the start bit two edges later.
// Backpressure: ready = FIFO not full; a send while full is dropped. Frames run back-to-back.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH_L   = (PW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // Input FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  // Transmit engine
  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          tx_q;
  logic          baud_done;
`ifdef UART_TX_PARITY_EN
  logic          parity_q;
`endif

  assign full      = (count == DEPTH_L);
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign push      = bus.send && !full;
  // The engine takes a byte when idle, or on the final stop cycle so the next start bit follows with no gap
  assign pop       = !empty && ((state == IDLE) || ((state == STOP) && baud_done));

  assign bus.ready = !full;
  assign bus.tx    = tx_q;
  assign bus.busy  = (state != IDLE) || !empty;

  // FIFO data array: written on accepted pushes only, contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_out;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer; tx is registered from the current state so it trails the state by one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_q     <= 1'b1;
          baud_cnt <= '0;
          if (!empty) begin
            shift    <= head;
            bit_cnt  <= '0;
            state    <= START;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^head;
`endif
          end
        end
        START: begin
          tx_q <= 1'b0;
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          tx_q <= shift[0];
          if (baud_done) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx_q <= parity_q;
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          tx_q <= 1'b1;
          if (baud_done) begin
            baud_cnt <= '0;
            if (!empty) begin
              shift    <= head;
              bit_cnt  <= '0;
              state    <= START;
`ifdef UART_TX_PARITY_EN
              parity_q <= ^head;
`endif
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx_q     <= 1'b1;
          baud_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, latency, frame shape, back-to-back, FIFO full/drop,
// same-edge push/pop, reset mid-frame, and (with UART_TX_PARITY_EN) the parity bit.
// All inputs change and all outputs are sampled on the falling clock edge.
module tb_uart_tx;

  localparam int B = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  uart_tx_if bus ();

  uart_tx #(.CLKS_PER_BIT(B), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Push one byte across one rising edge; data is scrambled afterwards since it need not be held
  task automatic push(input logic [7:0] b);
    bus.data_out = b;
    bus.send     = 1'b1;
    tick();
    bus.send     = 1'b0;
    bus.data_out = 8'($urandom);
  endtask

  // Expected line level for serial bit k of a frame carrying byte b
  function automatic logic line_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Cycle-accurate frame check; entered c0 cycles after the edge that drove the start bit
  task automatic check_frame(input logic [7:0] b, input int c0);
    for (int c = c0; c < NBITS * B; c++) begin
      check($sformatf("tx_%02h_bit%0d_cyc%0d", b, c / B, c % B), bus.tx, line_bit(b, c / B));
      tick();
    end
  endtask

  // Line must remain idle for n cycles
  task automatic check_idle(input string tag, input int n);
    int lows;
    lows = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.tx !== 1'b1) lows++;
      tick();
    end
    check(tag, lows, 0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.send     = 1'b0;
    bus.data_out = 8'h00;
    repeat (3) tick();
    check("rst_tx", bus.tx, 1'b1);
    check("rst_ready", bus.ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    tick();

    // Single byte: start bit two edges after acceptance, then 0x55 pattern
    push(8'h55);
    check("lat_busy_n", bus.busy, 1'b1);
    check("lat_tx_n", bus.tx, 1'b1);
    tick();
    check("lat_tx_n1", bus.tx, 1'b1);
    tick();
    check_frame(8'h55, 0);
    check("single_busy_end", bus.busy, 1'b0);
    check("single_tx_end", bus.tx, 1'b1);
    tick();

    // Back-to-back: second start bit directly after first stop bit
    push(8'h55);
    push(8'h77);
    tick();
    check_frame(8'h55, 0);
    check_frame(8'h77, 0);
    check("b2b_busy_end", bus.busy, 1'b0);
    tick();

    // Six pushes while idle: first pops at once, four fill the FIFO, sixth dropped
    push(8'hA1); check("fill_ready0", bus.ready, 1'b1);
    push(8'hB2); check("fill_ready1", bus.ready, 1'b1);
    push(8'hC3); check("fill_ready2", bus.ready, 1'b1);
    push(8'hD4); check("fill_ready3", bus.ready, 1'b1);
    push(8'hE5); check("fill_ready4", bus.ready, 1'b0);
    push(8'hF6); check("fill_ready5", bus.ready, 1'b0);
    check_frame(8'hA1, 3);
    check("fill_ready_after_pop", bus.ready, 1'b1);
    check_frame(8'hB2, 0);
    check_frame(8'hC3, 0);
    check_frame(8'hD4, 0);
    check_frame(8'hE5, 0);
    check("fill_busy_end", bus.busy, 1'b0);
    check_idle("fill_no_sixth_frame", NBITS * B);

    // Push coinciding with the stop-bit pop at occupancy 2
    push(8'h55);
    push(8'h3C);
    push(8'hC3);
    fork
      check_frame(8'h55, 0);
      begin
        repeat (78) tick();
        push(8'h5A);
        check("pp_ready_same_edge", bus.ready, 1'b1);
        push(8'hA5);
        check("pp_ready_occ3", bus.ready, 1'b1);
        push(8'h0F);
        check("pp_ready_occ4", bus.ready, 1'b0);
      end
    join
    check_frame(8'h3C, 1);
    check_frame(8'hC3, 0);
    check_frame(8'h5A, 0);
    check_frame(8'hA5, 0);
    check_frame(8'h0F, 0);
    check("pp_busy_end", bus.busy, 1'b0);
    tick();

    // Reset in the middle of a low data bit, with a byte still queued
    push(8'h55);
    push(8'h77);
    repeat (18) tick();
    check("mid_tx_low", bus.tx, 1'b0);
    rst = 1'b1;
    tick();
    check("mid_rst_tx", bus.tx, 1'b1);
    check("mid_rst_ready", bus.ready, 1'b1);
    rst = 1'b0;
    tick();
    check("mid_rst_busy", bus.busy, 1'b0);
    check_idle("mid_rst_abandoned", 2 * NBITS * B);

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 has three ones (parity 1), 0x03 has two (parity 0); 88-cycle frames
    push(8'h07);
    push(8'h03);
    tick();
    check_frame(8'h07, 0);
    check_frame(8'h03, 0);
    check("par_busy_end", bus.busy, 1'b0);
    check("par_tx_end", bus.tx, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
